sram_port_arbiter: RTL and testbench

// Shares the single-port 64KB SRAM between NUM_REQ requesters (e.g. DMA, PE load, writeback).

---
 rtl/sram_port_arbiter_pkg.sv | 28 ++
 rtl/sram_port_arbiter_if.sv | 40 ++++
 rtl/sram_port_arbiter_rr_picker.sv | 44 ++++
 rtl/sram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : sram_arb_pkg
// Brief   : Shared types and constants for the SRAM port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  localparam int SRAM_WORD_BITS = 14;
  localparam int SRAM_RANGE_HI  = 16;
  localparam int TAG_ID_BITS    = 3;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_ID_BITS-1:0] id;
    logic                   we;
    logic                   err;
  } resp_tag_t;

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : sram_port_arbiter_if
// Brief   : Requester, response and SRAM-side bundle of the SRAM port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*4-1:0]  req_wstrb;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ-1:0]    resp_valid;
  logic                  resp_err;
  logic [31:0]           resp_rdata;
  logic [3:0]            sram_WEB;
  logic [31:0]           sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  // master = requesters plus the SRAM macro; slave = the arbiter
  modport master (
    output req_valid, req_we, req_wstrb, req_addr, req_wdata, req_lock, sram_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, sram_WEB, sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_wstrb, req_addr, req_wdata, req_lock, sram_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, sram_WEB, sram_addr, sram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// Module  : rr_picker
// Brief   : Combinational round-robin pick: first set bit at or after ptr_i.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  logic [IDW:0] w_pos;

  // Scan from farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_pos   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, ptr_i} + (IDW+1)'(i);
      if (w_pos >= (IDW+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDW+1)'(NUM_REQ);
      end
      if (valid_i[w_pos[IDW-1:0]]) begin
        idx_o = w_pos[IDW-1:0];
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_port_arbiter
// Brief   : Round-robin, burst-lockable arbiter sharing one single-port SRAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 16
) (
  input logic                clk,
  input logic                rst,
  sram_port_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  C_BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] C_LAST_ID    = IDW'(NUM_REQ - 1);

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] owner_q;
  logic [CW-1:0]  burst_cnt_q;
  resp_tag_t      tag_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;

  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_strb;
  logic               w_sel_we;
  logic               w_sel_lock;
  logic               w_in_range;
  logic [31:0]        w_word;
  logic               w_unused_lsb;

  assign w_owner_oh = NUM_REQ'(1) << owner_q;

  // A locked owner that drops valid releases the port in the same cycle.
  always_comb begin
    w_elig = bus.req_valid;
    if (state_q == LOCKED && bus.req_valid[owner_q]) begin
      w_elig = bus.req_valid & w_owner_oh;
    end
    if (rst) begin
      w_elig = '0;
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .valid_i (w_elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_sel_addr   = bus.req_addr[w_idx*32 +: 32];
  assign w_sel_wdata  = bus.req_wdata[w_idx*32 +: 32];
  assign w_sel_strb   = bus.req_wstrb[w_idx*4 +: 4];
  assign w_sel_we     = bus.req_we[w_idx];
  assign w_sel_lock   = bus.req_lock[w_idx];
  assign w_in_range   = (w_sel_addr[31:SRAM_RANGE_HI] == '0);
  assign w_word       = {{(32-SRAM_WORD_BITS){1'b0}}, w_sel_addr[SRAM_WORD_BITS+1:2]};
  assign w_unused_lsb = ^w_sel_addr[1:0];

  assign bus.req_ready  = w_grant;
  assign bus.sram_addr  = w_any ? w_word : addr_q;
  assign bus.sram_wdata = w_any ? w_sel_wdata : wdata_q;
  assign bus.sram_WEB   = (w_any && w_sel_we && w_in_range) ? ~w_sel_strb : 4'hF;

  assign bus.resp_valid = tag_q.valid ? (NUM_REQ'(1) << tag_q.id) : '0;
  assign bus.resp_err   = tag_q.valid & tag_q.err;
  assign bus.resp_rdata = (tag_q.valid && !tag_q.we && !tag_q.err) ? bus.sram_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      tag_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      tag_q <= '{valid: w_any,
                 id:    w_any ? TAG_ID_BITS'(w_idx) : '0,
                 we:    w_any & w_sel_we,
                 err:   w_any & ~w_in_range};
      if (w_any) begin
        addr_q   <= w_word;
        wdata_q  <= w_sel_wdata;
        rr_ptr_q <= (w_idx == C_LAST_ID) ? '0 : w_idx + 1'b1;
        if (state_q == LOCKED && w_idx == owner_q) begin
          if (w_sel_lock && burst_cnt_q < C_BURST_LAST) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end else begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
          end
        end else if (w_sel_lock && MAX_BURST > 1) begin
          state_q     <= LOCKED;
          owner_q     <= w_idx;
          burst_cnt_q <= CW'(1);
        end else begin
          state_q     <= ARB;
          burst_cnt_q <= '0;
        end
      end else if (state_q == LOCKED) begin
        state_q     <= ARB;
        burst_cnt_q <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_port_arbiter
// Brief   : Directed self-checking bench for sram_port_arbiter with an SRAM model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_REQ(N)) bus ();

  sram_port_arbiter #(.NUM_REQ(N), .MAX_BURST(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered-read SRAM; 256 words, so 0x0001_0000 aliases word 0.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      bus.sram_rdata <= 32'h0;
    end else begin
      bus.sram_rdata <= mem[bus.sram_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (!bus.sram_WEB[b]) mem[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic idle_all();
    bus.req_valid = '0; bus.req_we = '0; bus.req_wstrb = '0;
    bus.req_addr  = '0; bus.req_wdata = '0; bus.req_lock = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] data, input logic lock);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = we;
    bus.req_lock[i]  = lock;
    bus.req_wstrb[i*4 +: 4]   = strb;
    bus.req_addr[i*32 +: 32]  = addr;
    bus.req_wdata[i*32 +: 32] = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_all();
    set_req(0, 1'b1, 4'hF, 32'h10, 32'h1, 1'b0);
    next_cycle();
    mid();
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 3'b000) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 000", bus.resp_valid); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL rst_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.sram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.sram_addr); end
    n_cmp++; if (bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", bus.sram_wdata); end
    idle_all();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    next_cycle(); idle_all();
    set_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_ready: got %b want 001", bus.req_ready); end
    n_cmp++; if (bus.sram_WEB !== 4'h0) begin n_fail++; $display("FAIL wr_web: got %h want 0", bus.sram_WEB); end
    n_cmp++; if (bus.sram_addr !== 32'h4) begin n_fail++; $display("FAIL wr_addr: got %h want 4", bus.sram_addr); end
    n_cmp++; if (bus.sram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", bus.sram_wdata); end
    next_cycle(); idle_all();
    set_req(1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL rd_ready: got %b want 010", bus.req_ready); end
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL rd_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.resp_valid !== 3'b001) begin n_fail++; $display("FAIL wr_resp: got %b want 001", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_resp_rdata: got %h want 0", bus.resp_rdata); end
    next_cycle(); idle_all();
    mid();
    n_cmp++; if (bus.resp_valid !== 3'b010) begin n_fail++; $display("FAIL rd_resp: got %b want 010", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_rdata: got %h want deadbeef", bus.resp_rdata); end
    n_cmp++; if (bus.sram_addr !== 32'h4) begin n_fail++; $display("FAIL idle_addr_hold: got %h want 4", bus.sram_addr); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b want 000", bus.req_ready); end
  endtask

  task automatic test_strobe();
    next_cycle(); idle_all();
    set_req(2, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL strb_ready: got %b want 100", bus.req_ready); end
    next_cycle();
    set_req(2, 1'b1, 4'b0101, 32'h20, 32'h11223344, 1'b0);
    mid();
    n_cmp++; if (bus.sram_WEB !== 4'hA) begin n_fail++; $display("FAIL strb_web: got %h want a", bus.sram_WEB); end
    n_cmp++; if (bus.sram_addr !== 32'h8) begin n_fail++; $display("FAIL strb_addr: got %h want 8", bus.sram_addr); end
    next_cycle();
    set_req(2, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL strb_rd_web: got %h want f", bus.sram_WEB); end
    next_cycle(); idle_all();
    mid();
    n_cmp++; if (bus.resp_valid !== 3'b100) begin n_fail++; $display("FAIL strb_resp: got %b want 100", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'hFF22FF44) begin n_fail++; $display("FAIL strb_rdata: got %h want ff22ff44", bus.resp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data [3];
    logic [2:0]  exp_g;
    exp_data[0] = 32'hDEADBEEF;
    exp_data[1] = 32'hFF22FF44;
    exp_data[2] = 32'h0;
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      if (k == 0) begin
        set_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
        set_req(1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        set_req(2, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
      end
      if (k == 6) idle_all();
      mid();
      if (k < 6) begin
        exp_g = 3'b001 << (k % 3);
        n_cmp++; if (bus.req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, exp_g); end
      end
      if (k > 0) begin
        exp_g = 3'b001 << ((k - 1) % 3);
        n_cmp++; if (bus.resp_valid !== exp_g) begin n_fail++; $display("FAIL rr_resp[%0d]: got %b want %b", k, bus.resp_valid, exp_g); end
        n_cmp++; if (bus.resp_rdata !== exp_data[(k-1)%3]) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, bus.resp_rdata, exp_data[(k-1)%3]); end
      end
    end
  endtask

  task automatic test_burst_lock();
    int         beats1 = 0;
    bit         done2  = 1'b0;
    logic [2:0] exp_g;
    for (int c = 0; c < 23; c++) begin
      next_cycle(); idle_all();
      if (beats1 < 20) set_req(1, 1'b0, 4'h0, 32'h40 + 32'(4 * beats1), 32'h0, 1'b1);
      if (!done2) set_req(2, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0);
      mid();
      exp_g = (c == 16) ? 3'b100 : ((c < 21) ? 3'b010 : 3'b000);
      n_cmp++; if (bus.req_ready !== exp_g) begin n_fail++; $display("FAIL burst_grant[%0d]: got %b want %b", c, bus.req_ready, exp_g); end
      if (bus.req_ready[1]) beats1++;
      if (bus.req_ready[2]) done2 = 1'b1;
    end
    idle_all();
  endtask

  task automatic test_out_of_range();
    next_cycle(); idle_all();
    set_req(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL oor_setup_ready: got %b want 001", bus.req_ready); end
    next_cycle();
    set_req(0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL oor_rd_ready: got %b want 001", bus.req_ready); end
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL oor_rd_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.sram_addr !== 32'h0) begin n_fail++; $display("FAIL oor_addr: got %h want 0", bus.sram_addr); end
    next_cycle();
    set_req(0, 1'b1, 4'hF, 32'h0001_0000, 32'h12345678, 1'b0);
    mid();
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL oor_wr_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.resp_valid !== 3'b001) begin n_fail++; $display("FAIL oor_resp: got %b want 001", bus.resp_valid); end
    n_cmp++; if (bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", bus.resp_err); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", bus.resp_rdata); end
    next_cycle();
    set_req(0, 1'b1, 4'h0, 32'h4, 32'h55555555, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL noop_ready: got %b want 001", bus.req_ready); end
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL noop_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", bus.resp_err); end
    next_cycle();
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.resp_valid !== 3'b001) begin n_fail++; $display("FAIL noop_resp: got %b want 001", bus.resp_valid); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL noop_err: got %b want 0", bus.resp_err); end
    next_cycle(); idle_all();
    mid();
    n_cmp++; if (bus.resp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oor_mem_kept: got %h want cafef00d", bus.resp_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    next_cycle(); idle_all();
    set_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL mb_first: got %b want 001", bus.req_ready); end
    next_cycle();
    set_req(1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL mb_locked: got %b want 001", bus.req_ready); end
    next_cycle();
    rst = 1'b1;
    mid();
    n_cmp++; if (bus.resp_valid !== 3'b000) begin n_fail++; $display("FAIL mb_rst_resp: got %b want 000", bus.resp_valid); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL mb_rst_err: got %b want 0", bus.resp_err); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL mb_rst_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL mb_rst_ready: got %b want 000", bus.req_ready); end
    n_cmp++; if (bus.sram_WEB !== 4'hF) begin n_fail++; $display("FAIL mb_rst_web: got %h want f", bus.sram_WEB); end
    n_cmp++; if (bus.sram_addr !== 32'h0) begin n_fail++; $display("FAIL mb_rst_addr: got %h want 0", bus.sram_addr); end
    n_cmp++; if (bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL mb_rst_wdata: got %h want 0", bus.sram_wdata); end
    next_cycle(); idle_all();
    next_cycle();
    rst = 1'b0;
    mid();
    n_cmp++; if (bus.resp_valid !== 3'b000) begin n_fail++; $display("FAIL mb_post_resp: got %b want 000", bus.resp_valid); end
    next_cycle();
    set_req(2, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    mid();
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL mb_post_grant: got %b want 100", bus.req_ready); end
    next_cycle(); idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_strobe();
    test_round_robin();
    test_burst_lock();
    test_out_of_range();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
